uart_tx_ctrl: RTL and testbench

- UART transmit controller: accepts a parallel word and sequences one frame per word onto the serial line.
- Frame order: start bit, data bits LSB-first, optional parity bit, stop bit.
- Owns the 4-way bit-source mux select, the data shift register, the bit counter and the parity calculation.
- Sits between the APB-side TX buffer and the TX pin; CLK runs at the baud rate, one bit per CLK cycle.

---
 rtl/uart_tx_pkg.sv | 36 +++
 rtl/uart_tx_serializer.sv | 51 +++++
 rtl/uart_tx_ctrl.sv | 123 ++++++++++++
 tb/tb_uart_tx_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit controller: FSM state encoding,
// bit-source select codes and the line-level bit mux.
package uart_tx_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_START  = ST_START,
    S_DATA   = ST_DATA,
    S_PARITY = ST_PARITY,
    S_STOP   = ST_STOP
  } state_e;

  localparam logic [1:0] SEL_START = 2'd0;
  localparam logic [1:0] SEL_STOP  = 2'd1;
  localparam logic [1:0] SEL_DATA  = 2'd2;
  localparam logic [1:0] SEL_PAR   = 2'd3;

  // Any select code outside the three active sources drives the idle level.
  function automatic logic tx_bit_mux(input logic [1:0] sel,
                                      input logic       data_bit,
                                      input logic       par_bit);
    case (sel)
      SEL_START: return 1'b0;
      SEL_DATA:  return data_bit;
      SEL_PAR:   return par_bit;
      default:   return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// Data shift register and bit counter for one UART frame; done_o flags the
// last data bit so the controller can leave the DATA state.
module uart_tx_serializer
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  clr_i,
  input  logic                  shift_i,
  output logic                  bit_o,
  output logic                  done_o
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (load_i) begin
      shift_d = data_i;
    end else if (shift_i) begin
      shift_d = shift_q >> 1;
    end
    if (clr_i) begin
      cnt_d = '0;
    end else if (shift_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bit_o  = shift_q[0];
  assign done_o = (cnt_q == CNT_W'(DATA_WIDTH - 1));

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: frame FSM, latched parity configuration and the
// bit-source mux driving TX_OUT. One bit per CLK cycle.
module uart_tx_ctrl
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  BUSY,
  output logic [1:0]            MUX_SEL
);

  state_e state_q, state_d;
  logic   par_en_q, par_en_d;
  logic   par_typ_q, par_typ_d;
  logic   data_par_q, data_par_d;

  logic   load_w;
  logic   clr_w;
  logic   shift_w;
  logic   ser_bit_w;
  logic   ser_done_w;
  logic   par_bit_w;

  uart_tx_serializer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_ser (
    .clk_i   (CLK),
    .rst_n_i (RST),
    .load_i  (load_w),
    .data_i  (P_DATA),
    .clr_i   (clr_w),
    .shift_i (shift_w),
    .bit_o   (ser_bit_w),
    .done_o  (ser_done_w)
  );

  // A new word is accepted only from IDLE or on the STOP edge (back-to-back).
  always_comb begin
    state_d    = state_q;
    par_en_d   = par_en_q;
    par_typ_d  = par_typ_q;
    data_par_d = data_par_q;
    load_w     = 1'b0;
    clr_w      = 1'b0;
    shift_w    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (DATA_VALID) begin
          load_w  = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        clr_w   = 1'b1;
        state_d = S_DATA;
      end
      S_DATA: begin
        shift_w = 1'b1;
        if (ser_done_w) begin
          state_d = par_en_q ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        state_d = S_STOP;
      end
      S_STOP: begin
        if (DATA_VALID) begin
          load_w  = 1'b1;
          state_d = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (load_w) begin
      par_en_d   = PAR_EN;
      par_typ_d  = PAR_TYP;
      data_par_d = ^P_DATA;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= S_IDLE;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      data_par_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      par_en_q   <= par_en_d;
      par_typ_q  <= par_typ_d;
      data_par_q <= data_par_d;
    end
  end

  // Select and BUSY depend on the state register alone, so TX_OUT only
  // changes as a function of flop outputs.
  always_comb begin
    MUX_SEL = SEL_STOP;
    BUSY    = 1'b0;
    case (state_q)
      S_START:  begin MUX_SEL = SEL_START; BUSY = 1'b1; end
      S_DATA:   begin MUX_SEL = SEL_DATA;  BUSY = 1'b1; end
      S_PARITY: begin MUX_SEL = SEL_PAR;   BUSY = 1'b1; end
      S_STOP:   begin MUX_SEL = SEL_STOP;  BUSY = 1'b1; end
      default:  begin MUX_SEL = SEL_STOP;  BUSY = 1'b0; end
    endcase
  end

  assign par_bit_w = data_par_q ^ par_typ_q;
  assign TX_OUT    = tx_bit_mux(MUX_SEL, ser_bit_w, par_bit_w);

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: directed and random frames compared against a
// frame-position model of the serial line.
module tb_uart_tx_ctrl;

  localparam int DW = 8;

  logic          CLK = 1'b0;
  logic          RST;
  logic [DW-1:0] P_DATA;
  logic          DATA_VALID;
  logic          PAR_EN;
  logic          PAR_TYP;
  logic          TX_OUT;
  logic          BUSY;
  logic [1:0]    MUX_SEL;

  int n_tests = 0;
  int n_fail  = 0;

  uart_tx_ctrl #(.DATA_WIDTH(DW)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .TX_OUT     (TX_OUT),
    .BUSY       (BUSY),
    .MUX_SEL    (MUX_SEL)
  );

  always #5 CLK = ~CLK;

  // Line level at position i of a frame: start, LSB-first data, parity, stop.
  function automatic logic exp_bit(input logic [DW-1:0] d, input logic pen,
                                   input logic typ, input int i);
    if (i == 0) return 1'b0;
    if (i <= DW) return d[i-1];
    if (pen && i == DW + 1) return (^d) ^ typ;
    return 1'b1;
  endfunction

  function automatic logic [1:0] exp_sel(input logic pen, input int i);
    if (i == 0) return 2'd0;
    if (i <= DW) return 2'd2;
    if (pen && i == DW + 1) return 2'd3;
    return 2'd1;
  endfunction

  function automatic int frame_len(input logic pen);
    return DW + 2 + (pen ? 1 : 0);
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b0;
    for (int i = 0; i < 5; i++) begin
      P_DATA = DW'($urandom); DATA_VALID = 1'($urandom);
      PAR_EN = 1'($urandom); PAR_TYP = 1'($urandom);
      tick();
      n_tests++;
      if ({TX_OUT, BUSY, MUX_SEL} !== 4'b1001) begin
        n_fail++;
        $display("FAIL reset_hold cyc %0d: tx/busy/sel=%b expected 1001", i, {TX_OUT, BUSY, MUX_SEL});
      end
    end
    DATA_VALID = 1'b0;
    RST = 1'b1;
    for (int i = 0; i < 20; i++) begin
      P_DATA = DW'($urandom);
      tick();
      n_tests++;
      if ({TX_OUT, BUSY, MUX_SEL} !== 4'b1001) begin
        n_fail++;
        $display("FAIL reset_idle cyc %0d: tx/busy/sel=%b expected 1001", i, {TX_OUT, BUSY, MUX_SEL});
      end
    end
  endtask

  task automatic test_no_parity();
    logic [DW-1:0] w;
    int len;
    w = 8'hA5;
    P_DATA = w; PAR_EN = 1'b0; PAR_TYP = 1'($urandom); DATA_VALID = 1'b1;
    tick();
    DATA_VALID = 1'b0;
    len = frame_len(1'b0);
    for (int i = 0; i < len; i++) begin
      n_tests++;
      if ({TX_OUT, BUSY, MUX_SEL} !== {exp_bit(w, 1'b0, 1'b0, i), 1'b1, exp_sel(1'b0, i)}) begin
        n_fail++;
        $display("FAIL nopar pos %0d: tx/busy/sel=%b expected %b", i, {TX_OUT, BUSY, MUX_SEL},
                 {exp_bit(w, 1'b0, 1'b0, i), 1'b1, exp_sel(1'b0, i)});
      end
      if (i == 0) P_DATA = DW'($urandom);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if ({TX_OUT, BUSY, MUX_SEL} !== 4'b1001) begin
        n_fail++;
        $display("FAIL nopar_idle cyc %0d: tx/busy/sel=%b expected 1001", i, {TX_OUT, BUSY, MUX_SEL});
      end
      tick();
    end
  endtask

  task automatic test_parity();
    logic [DW-1:0] words [3];
    logic          typs  [3];
    logic          pbit  [3];
    int len;
    words[0] = 8'hA5; typs[0] = 1'b0; pbit[0] = 1'b0;
    words[1] = 8'hA5; typs[1] = 1'b1; pbit[1] = 1'b1;
    words[2] = 8'h07; typs[2] = 1'b0; pbit[2] = 1'b1;
    for (int f = 0; f < 3; f++) begin
      P_DATA = words[f]; PAR_EN = 1'b1; PAR_TYP = typs[f]; DATA_VALID = 1'b1;
      tick();
      DATA_VALID = 1'b0;
      len = frame_len(1'b1);
      for (int i = 0; i < len; i++) begin
        n_tests++;
        if ({TX_OUT, BUSY, MUX_SEL} !== {exp_bit(words[f], 1'b1, typs[f], i), 1'b1, exp_sel(1'b1, i)}) begin
          n_fail++;
          $display("FAIL par f%0d pos %0d: tx/busy/sel=%b expected %b", f, i, {TX_OUT, BUSY, MUX_SEL},
                   {exp_bit(words[f], 1'b1, typs[f], i), 1'b1, exp_sel(1'b1, i)});
        end
        if (i == DW + 1) begin
          n_tests++;
          if (TX_OUT !== pbit[f]) begin
            n_fail++;
            $display("FAIL par_bit f%0d: tx=%b expected %b", f, TX_OUT, pbit[f]);
          end
        end
        if (i == 0) begin PAR_EN = 1'($urandom); PAR_TYP = 1'($urandom); end
        tick();
      end
      n_tests++;
      if ({TX_OUT, BUSY} !== 2'b10) begin
        n_fail++;
        $display("FAIL par_end f%0d: tx/busy=%b expected 10", f, {TX_OUT, BUSY});
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] w0, w1;
    logic eb;
    w0 = 8'h55; w1 = 8'h0F;
    P_DATA = w0; PAR_EN = 1'b0; PAR_TYP = 1'b0; DATA_VALID = 1'b1;
    tick();
    for (int i = 0; i < 20; i++) begin
      eb = (i < 10) ? exp_bit(w0, 1'b0, 1'b0, i) : exp_bit(w1, 1'b0, 1'b0, i - 10);
      n_tests++;
      if ({TX_OUT, BUSY} !== {eb, 1'b1}) begin
        n_fail++;
        $display("FAIL b2b pos %0d: tx/busy=%b expected %b", i, {TX_OUT, BUSY}, {eb, 1'b1});
      end
      if (i == 9) P_DATA = w1;
      if (i == 10) DATA_VALID = 1'b0;
      tick();
    end
    n_tests++;
    if ({TX_OUT, BUSY, MUX_SEL} !== 4'b1001) begin
      n_fail++;
      $display("FAIL b2b_end: tx/busy/sel=%b expected 1001", {TX_OUT, BUSY, MUX_SEL});
    end
  endtask

  task automatic test_ignored();
    logic [DW-1:0] w;
    int len;
    w = 8'hA5;
    P_DATA = w; PAR_EN = 1'b0; PAR_TYP = 1'b0; DATA_VALID = 1'b1;
    tick();
    DATA_VALID = 1'b0;
    len = frame_len(1'b0);
    for (int i = 0; i < len; i++) begin
      n_tests++;
      if ({TX_OUT, BUSY, MUX_SEL} !== {exp_bit(w, 1'b0, 1'b0, i), 1'b1, exp_sel(1'b0, i)}) begin
        n_fail++;
        $display("FAIL ignored pos %0d: tx/busy/sel=%b expected %b", i, {TX_OUT, BUSY, MUX_SEL},
                 {exp_bit(w, 1'b0, 1'b0, i), 1'b1, exp_sel(1'b0, i)});
      end
      if (i == 4) begin DATA_VALID = 1'b1; P_DATA = 8'hFF; PAR_EN = 1'b1; end
      if (i == 5) begin DATA_VALID = 1'b0; PAR_EN = 1'b0; end
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if ({TX_OUT, BUSY, MUX_SEL} !== 4'b1001) begin
        n_fail++;
        $display("FAIL ignored_idle cyc %0d: tx/busy/sel=%b expected 1001", i, {TX_OUT, BUSY, MUX_SEL});
      end
      tick();
    end
  endtask

  task automatic test_reset_midframe();
    logic [DW-1:0] w;
    w = 8'hA5;
    P_DATA = w; PAR_EN = 1'b1; PAR_TYP = 1'b1; DATA_VALID = 1'b1;
    tick();
    DATA_VALID = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if ({TX_OUT, BUSY} !== {exp_bit(w, 1'b1, 1'b1, i), 1'b1}) begin
        n_fail++;
        $display("FAIL rstmid pos %0d: tx/busy=%b expected %b", i, {TX_OUT, BUSY}, {exp_bit(w, 1'b1, 1'b1, i), 1'b1});
      end
      tick();
    end
    RST = 1'b0;
    #1;
    n_tests++;
    if ({TX_OUT, BUSY, MUX_SEL} !== 4'b1001) begin
      n_fail++;
      $display("FAIL rstmid_async: tx/busy/sel=%b expected 1001", {TX_OUT, BUSY, MUX_SEL});
    end
    tick();
    tick();
    RST = 1'b1;
    for (int i = 0; i < 12; i++) begin
      n_tests++;
      if ({TX_OUT, BUSY, MUX_SEL} !== 4'b1001) begin
        n_fail++;
        $display("FAIL rstmid_idle cyc %0d: tx/busy/sel=%b expected 1001", i, {TX_OUT, BUSY, MUX_SEL});
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] w;
    logic pen, typ, chain;
    int len, gap;
    w = DW'($urandom); pen = 1'($urandom); typ = 1'($urandom);
    P_DATA = w; PAR_EN = pen; PAR_TYP = typ; DATA_VALID = 1'b1;
    tick();
    for (int f = 0; f < 40; f++) begin
      chain = (f < 39) && ($urandom_range(0, 1) == 1);
      len = frame_len(pen);
      for (int i = 0; i < len; i++) begin
        n_tests++;
        if ({TX_OUT, BUSY, MUX_SEL} !== {exp_bit(w, pen, typ, i), 1'b1, exp_sel(pen, i)}) begin
          n_fail++;
          $display("FAIL rand f%0d pos %0d data %h pen %b typ %b: tx/busy/sel=%b expected %b", f, i, w, pen, typ,
                   {TX_OUT, BUSY, MUX_SEL}, {exp_bit(w, pen, typ, i), 1'b1, exp_sel(pen, i)});
        end
        if (i == 0) begin
          DATA_VALID = 1'($urandom); P_DATA = DW'($urandom);
          PAR_EN = 1'($urandom); PAR_TYP = 1'($urandom);
        end
        if (i == 1) DATA_VALID = 1'b0;
        if (i == len - 1) begin
          if (chain) begin
            w = DW'($urandom); pen = 1'($urandom); typ = 1'($urandom);
            P_DATA = w; PAR_EN = pen; PAR_TYP = typ; DATA_VALID = 1'b1;
          end else begin
            DATA_VALID = 1'b0;
          end
        end
        tick();
      end
      if (!chain) begin
        gap = $urandom_range(0, 3);
        for (int g = 0; g <= gap; g++) begin
          n_tests++;
          if ({TX_OUT, BUSY, MUX_SEL} !== 4'b1001) begin
            n_fail++;
            $display("FAIL rand_idle f%0d: tx/busy/sel=%b expected 1001", f, {TX_OUT, BUSY, MUX_SEL});
          end
          if (g < gap) tick();
        end
        if (f < 39) begin
          w = DW'($urandom); pen = 1'($urandom); typ = 1'($urandom);
          P_DATA = w; PAR_EN = pen; PAR_TYP = typ; DATA_VALID = 1'b1;
          tick();
        end
      end
    end
    DATA_VALID = 1'b0;
  endtask

  initial begin
    RST = 1'b0; P_DATA = '0; DATA_VALID = 1'b0; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    test_reset();
    test_no_parity();
    test_parity();
    test_back_to_back();
    test_ignored();
    test_reset_midframe();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
